// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types and constants for the cache line-fill engine.
//  Revision    : 1.0  initial release
// ============================================================================
package cache_pkg;

    // Refill engine states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        LAST_WR = 2'd2,
        DONE    = 2'd3
    } refill_state_e;

    // Default group size and its beat-index width
    localparam int GROUP_WORDS_DEF = 4;
    localparam int GROUP_W         = $clog2(GROUP_WORDS_DEF);

    // Cache slot address layout: {block, word}
    localparam int SLOT_ADDR_W  = 8;
    localparam int SLOT_BLOCK_W = 3;
    localparam int SLOT_WORD_W  = 5;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_refill_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cache_refill_seq
//  Description : Beat counter and beat-order generator for one group refill.
//                Produces the current beat index (start + count, wrapping
//                within the group) and a flag marking the final beat.
//                Macro CACHE_REFILL_CRITICAL_FIRST_EN: start at the missed
//                word instead of word 0.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_refill_seq #(
    parameter int GROUP_WORDS = 4
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_srst,
    input  logic                           i_load,
    input  logic [$clog2(GROUP_WORDS)-1:0] i_start_word,
    input  logic                           i_advance,
    output logic [$clog2(GROUP_WORDS)-1:0] o_beat_idx,
    output logic                           o_last
);

    localparam int BEAT_W = $clog2(GROUP_WORDS);
    localparam logic [BEAT_W-1:0] LAST_CNT = BEAT_W'(GROUP_WORDS - 1);

`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
    localparam logic CRIT_FIRST = 1'b1;
`else
    localparam logic CRIT_FIRST = 1'b0;
`endif

    logic [BEAT_W-1:0] start_q;
    logic [BEAT_W-1:0] cnt_q;
    logic [BEAT_W-1:0] w_start;

    assign w_start = CRIT_FIRST ? i_start_word : '0;

    // Latch the starting word on a new refill, count acknowledged beats
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            start_q <= '0;
            cnt_q   <= '0;
        end else if (i_srst) begin
            start_q <= '0;
            cnt_q   <= '0;
        end else if (i_load) begin
            start_q <= w_start;
            cnt_q   <= '0;
        end else if (i_advance) begin
            cnt_q   <= cnt_q + BEAT_W'(1);
        end
    end

    // Power-of-two group: natural overflow wraps inside the group
    assign o_beat_idx = start_q + cnt_q;
    assign o_last     = (cnt_q == LAST_CNT);

endmodule : cache_refill_seq
`default_nettype wire

// File: rtl/cache_refill.sv
`default_nettype none
// ============================================================================
//  Module      : cache_refill
//  Description : Line-fill engine. Accepts a miss, fetches one group of
//                GROUP_WORDS words over a req/ack memory interface, writes
//                each word to the cache data RAM and pulses o_wr_ready once
//                the group is complete.
//                Macro CACHE_REFILL_CRITICAL_FIRST_EN: fetch the missed word
//                first, then wrap ascending within the group.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_refill
    import cache_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 30,
    parameter int GROUP_WORDS = GROUP_WORDS_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_srst,
    input  logic                   i_miss,
    input  logic [SLOT_ADDR_W-1:0] i_load_addr,
    input  logic [ADDR_W-1:0]      i_miss_addr,
    output logic                   o_busy,
    output logic                   o_mem_req,
    output logic [ADDR_W-1:0]      o_mem_addr,
    input  logic                   i_mem_ack,
    input  logic [DATA_W-1:0]      i_mem_rdata,
    output logic                   o_cache_we,
    output logic [SLOT_ADDR_W-1:0] o_cache_addr,
    output logic [DATA_W-1:0]      o_cache_wdata,
    output logic                   o_wr_ready
);

    localparam int BEAT_W      = $clog2(GROUP_WORDS);
    localparam int SLOT_BASE_W = SLOT_ADDR_W - BEAT_W;
    localparam int MEM_BASE_W  = ADDR_W - BEAT_W;

    refill_state_e          state_q;
    refill_state_e          state_d;

    logic [MEM_BASE_W-1:0]  mem_base_q;
    logic [SLOT_BASE_W-1:0] slot_base_q;
    logic                   wr_en_q;
    logic [BEAT_W-1:0]      wr_idx_q;
    logic [DATA_W-1:0]      wdata_q;

    logic                   w_load;
    logic                   w_beat_ack;
    logic [BEAT_W-1:0]      w_beat_idx;
    logic                   w_last_beat;
    logic                   w_unused_load_lo;

    // Word bits of the slot address are replaced by the beat index
    assign w_unused_load_lo = ^i_load_addr[BEAT_W-1:0];

    // Miss accepted only in IDLE; ack counts only while requesting
    assign w_load     = (state_q == IDLE) && i_miss;
    assign w_beat_ack = (state_q == FETCH) && i_mem_ack;

    cache_refill_seq #(
        .GROUP_WORDS (GROUP_WORDS)
    ) u_seq (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_srst       (i_srst),
        .i_load       (w_load),
        .i_start_word (i_miss_addr[BEAT_W-1:0]),
        .i_advance    (w_beat_ack),
        .o_beat_idx   (w_beat_idx),
        .o_last       (w_last_beat)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else if (i_srst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status/handshake outputs
    always_comb begin
        state_d    = state_q;
        o_busy     = 1'b0;
        o_mem_req  = 1'b0;
        o_wr_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_miss) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                o_busy    = 1'b1;
                o_mem_req = 1'b1;
                if (i_mem_ack && w_last_beat) begin
                    state_d = LAST_WR;
                end
            end
            LAST_WR: begin
                o_busy  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                o_busy     = 1'b1;
                o_wr_ready = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Group bases captured at accept; each acked beat queued for a RAM write
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mem_base_q  <= '0;
            slot_base_q <= '0;
            wr_en_q     <= 1'b0;
            wr_idx_q    <= '0;
            wdata_q     <= '0;
        end else if (i_srst) begin
            mem_base_q  <= '0;
            slot_base_q <= '0;
            wr_en_q     <= 1'b0;
            wr_idx_q    <= '0;
            wdata_q     <= '0;
        end else begin
            if (w_load) begin
                mem_base_q  <= i_miss_addr[ADDR_W-1:BEAT_W];
                slot_base_q <= i_load_addr[SLOT_ADDR_W-1:BEAT_W];
            end
            wr_en_q <= w_beat_ack;
            if (w_beat_ack) begin
                wr_idx_q <= w_beat_idx;
                wdata_q  <= i_mem_rdata;
            end
        end
    end

    assign o_mem_addr    = {mem_base_q, w_beat_idx};
    assign o_cache_we    = wr_en_q;
    assign o_cache_addr  = {slot_base_q, wr_idx_q};
    assign o_cache_wdata = wdata_q;

endmodule : cache_refill
`default_nettype wire
